// File: rtl/fpu_scheduler.sv
// Round-robin front end sharing one combinational FPU between two requesters.
// Optional per-requester completion counters are built when FPU_SCHED_OPCOUNT_EN is defined.
module fpu_scheduler #(
    parameter int EXEC_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [1:0]       req1_op,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_ctrl,
    input  logic [31:0]      fpu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count0,
    output logic [CNT_W-1:0] op_count1
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q;
    logic [3:0]  cnt_q;
    logic [31:0] a_q, b_q, data_q;
    logic [1:0]  op_q;
    logic        id_q;

    logic grant_id_s, grant_vld_s, accept_s, exec_done_s, handshake_s;

    // Half-precision ops only produce a 16-bit result.
    function automatic logic [31:0] mask_result(input logic [31:0] res, input logic [1:0] op);
        if (op[0]) begin
            return res;
        end else begin
            return {16'h0000, res[15:0]};
        end
    endfunction

    assign grant_vld_s = |req_valid;
    assign accept_s    = (state_q == ST_IDLE) && grant_vld_s;
    assign exec_done_s = (state_q == ST_EXEC) && (cnt_q == 4'd0);
    assign handshake_s = (state_q == ST_DONE) && resp_ready;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    always_comb begin
        grant_id_s = 1'b0;
        case (req_valid)
            2'b01:   grant_id_s = 1'b0;
            2'b10:   grant_id_s = 1'b1;
            2'b11:   grant_id_s = ~last_q;
            default: grant_id_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_EXEC;
                else          state_d = ST_IDLE;
            end
            ST_EXEC: begin
                if (exec_done_s) state_d = ST_DONE;
                else             state_d = ST_EXEC;
            end
            ST_DONE: begin
                if (handshake_s) state_d = ST_IDLE;
                else             state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoded handshake and status outputs.
    always_comb begin
        req_ready  = 2'b00;
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) req_ready = grant_id_s ? 2'b10 : 2'b01;
                else             req_ready = 2'b00;
            end
            ST_EXEC: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // Operand capture, execution countdown and result sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= 32'h0000_0000;
            b_q    <= 32'h0000_0000;
            op_q   <= 2'b00;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            cnt_q  <= 4'd0;
            data_q <= 32'h0000_0000;
        end else if (accept_s) begin
            a_q    <= grant_id_s ? req1_a  : req0_a;
            b_q    <= grant_id_s ? req1_b  : req0_b;
            op_q   <= grant_id_s ? req1_op : req0_op;
            id_q   <= grant_id_s;
            last_q <= grant_id_s;
            cnt_q  <= CNT_LOAD;
        end else if (exec_done_s) begin
            data_q <= mask_result(fpu_result, op_q);
        end else if (state_q == ST_EXEC) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign fpu_ctrl  = op_q;
    assign resp_id   = id_q;
    assign resp_data = data_q;

`ifdef FPU_SCHED_OPCOUNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Completed-op counters, credited to the owner at the response handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (handshake_s) begin
            if (id_q) cnt1_q <= cnt1_q + CNT_W'(1);
            else      cnt0_q <= cnt0_q + CNT_W'(1);
        end
    end

    assign op_count0 = cnt0_q;
    assign op_count1 = cnt1_q;
`else
    assign op_count0 = '0;
    assign op_count1 = '0;
`endif

endmodule

// File: tb/tb_fpu_scheduler.sv
// Self-checking bench for fpu_scheduler with a stand-in FPU and a transaction-level model.
module tb_fpu_scheduler;

    localparam int EXEC     = 2;
    localparam int TB_CNT_W = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          req_valid, req_ready;
    logic [31:0]         req0_a, req0_b, req1_a, req1_b;
    logic [1:0]          req0_op, req1_op;
    logic [31:0]         fpu_a, fpu_b, fpu_result;
    logic [1:0]          fpu_ctrl;
    logic                resp_valid, resp_ready, resp_id, busy;
    logic [31:0]         resp_data;
    logic [TB_CNT_W-1:0] op_count0, op_count1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic        m_last;
    int          m_cnt0, m_cnt1;
    logic [31:0] m_a;

    fpu_scheduler #(.EXEC_CYCLES(EXEC), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ctrl(fpu_ctrl), .fpu_result(fpu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .busy(busy), .op_count0(op_count0), .op_count1(op_count1)
    );

    always #5 clk = ~clk;

    // Stand-in FPU: known IEEE answers for the directed vectors, a scramble otherwise.
    function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (op == 2'b01 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        else if (op == 2'b00 && a == 32'h00003C00 && b == 32'h00003C00) return 32'hBEEF4000;
        else if (op == 2'b11 && a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
        else return (a + {b[15:0], b[31:16]}) ^ {op, 30'h15A5C3E1};
    endfunction

    assign fpu_result = fake_fpu(fpu_a, fpu_b, fpu_ctrl);

    function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [31:0] r;
        r = fake_fpu(a, b, op);
        return op[0] ? r : {16'h0000, r[15:0]};
    endfunction

    function automatic logic [TB_CNT_W-1:0] exp_count(input int c);
`ifdef FPU_SCHED_OPCOUNT_EN
        return TB_CNT_W'(c);
`else
        return TB_CNT_W'(0);
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0; m_a = 32'h0;
    endtask

    // One full request/response transaction, predicted from the arbitration rules.
    task automatic do_txn(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] o0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] o1, input int bp);
        logic g;
        logic [31:0] ea, eb, ed;
        logic [1:0] eo;
        @(negedge clk);
        req_valid = v; req0_a = a0; req0_b = b0; req0_op = o0;
        req1_a = a1; req1_b = b1; req1_op = o1;
        resp_ready = 1'($urandom_range(0, 1));
        if (v == 2'b11) g = ~m_last;
        else            g = (v == 2'b10);
        ea = g ? a1 : a0; eb = g ? b1 : b0; eo = g ? o1 : o0;
        ed = exp_data(ea, eb, eo);
        #1;
        n_vec++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL grant got %b exp %b", req_ready, (g ? 2'b10 : 2'b01)); end
        n_vec++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL idle_status busy %b rv %b exp 0 0", busy, resp_valid); end
        n_vec++; if (op_count0 !== exp_count(m_cnt0) || op_count1 !== exp_count(m_cnt1)) begin n_err++;
            $display("FAIL op_count got %0d/%0d exp %0d/%0d", op_count0, op_count1, exp_count(m_cnt0), exp_count(m_cnt1)); end
        @(posedge clk);
        m_last = g; m_a = ea;
        for (int k = 0; k < EXEC; k++) begin
            @(negedge clk);
            req_valid = 2'($urandom); req0_a = $urandom; req1_a = $urandom; req0_op = 2'($urandom);
            resp_ready = 1'($urandom_range(0, 1));
            #1;
            n_vec++; if (busy !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 2'b00) begin n_err++;
                $display("FAIL exec_status busy %b rv %b rdy %b exp 1 0 00", busy, resp_valid, req_ready); end
            n_vec++; if (fpu_a !== ea || fpu_b !== eb || fpu_ctrl !== eo) begin n_err++;
                $display("FAIL exec_operands got %h %h %b exp %h %h %b", fpu_a, fpu_b, fpu_ctrl, ea, eb, eo); end
            @(posedge clk);
        end
        for (int k = 0; k <= bp; k++) begin
            @(negedge clk);
            req_valid = 2'($urandom);
            resp_ready = (k == bp);
            #1;
            n_vec++; if (resp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 2'b00) begin n_err++;
                $display("FAIL done_status rv %b busy %b rdy %b exp 1 1 00", resp_valid, busy, req_ready); end
            n_vec++; if (resp_data !== ed || resp_id !== g) begin n_err++;
                $display("FAIL resp got %h id %b exp %h id %b", resp_data, resp_id, ed, g); end
            @(posedge clk);
        end
        if (g) m_cnt1++;
        else   m_cnt0++;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
        req0_a = 32'h0; req0_b = 32'h0; req0_op = 2'b00;
        req1_a = 32'h0; req1_b = 32'h0; req1_op = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (req_ready !== 2'b00 || resp_valid !== 1'b0 || busy !== 1'b0) begin n_err++;
            $display("FAIL reset_status rdy %b rv %b busy %b exp 00 0 0", req_ready, resp_valid, busy); end
        n_vec++; if (resp_id !== 1'b0 || resp_data !== 32'h0) begin n_err++;
            $display("FAIL reset_resp id %b data %h exp 0 0", resp_id, resp_data); end
        n_vec++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0 || fpu_ctrl !== 2'b00) begin n_err++;
            $display("FAIL reset_fpu got %h %h %b exp 0 0 00", fpu_a, fpu_b, fpu_ctrl); end
        n_vec++; if (op_count0 !== '0 || op_count1 !== '0) begin n_err++;
            $display("FAIL reset_count got %0d %0d exp 0 0", op_count0, op_count1); end
        @(negedge clk);
        reset = 1'b0;
        m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0; m_a = 32'h0;
    endtask

    task automatic test_add32_r0();
        do_txn(2'b01, 32'h3F800000, 32'h40000000, 2'b01, 32'h0, 32'h0, 2'b00, 0);
    endtask

    task automatic test_add16_r1();
        do_txn(2'b10, 32'h0, 32'h0, 2'b00, 32'h00003C00, 32'h00003C00, 2'b00, 0);
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom), 0);
    endtask

    task automatic test_backpressure();
        do_txn(2'b01, 32'h3FC00000, 32'h40000000, 2'b11, 32'h0, 32'h0, 2'b00, 5);
        do_txn(2'b10, 32'h0, 32'h0, 2'b00, 32'h3F800000, 32'h40000000, 2'b01, 0);
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 2'b00; resp_ready = 1'b1;
            #1;
            n_vec++; if (busy !== 1'b0 || req_ready !== 2'b00 || resp_valid !== 1'b0 || fpu_a !== m_a) begin n_err++;
                $display("FAIL idle_hold busy %b rdy %b rv %b a %h exp 0 00 0 %h", busy, req_ready, resp_valid, fpu_a, m_a); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            do_txn(2'($urandom_range(1, 3)), $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom),
                   $urandom_range(0, 3));
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        req_valid = 2'b11; req0_a = 32'h12345678; req1_a = 32'h9ABCDEF0; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || resp_valid !== 1'b0 || fpu_a !== 32'h0) begin n_err++;
            $display("FAIL mid_reset busy %b rv %b a %h exp 0 0 0", busy, resp_valid, fpu_a); end
        n_vec++; if (op_count0 !== '0 || op_count1 !== '0) begin n_err++;
            $display("FAIL mid_reset_count got %0d %0d exp 0 0", op_count0, op_count1); end
        @(negedge clk);
        reset = 1'b0;
        m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0; m_a = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_noresp rv %b exp 0", resp_valid); end
        end
        do_txn(2'b11, 32'h0, 32'h7FC00000, 2'b01, 32'h1, 32'h2, 2'b10, 1);
    endtask

    task automatic test_opcount();
        do_reset();
        for (int i = 0; i < 5; i++) do_txn(2'b01, $urandom, $urandom, 2'($urandom), 32'h0, 32'h0, 2'b00, 0);
        for (int i = 0; i < 2; i++) do_txn(2'b10, 32'h0, 32'h0, 2'b00, $urandom, $urandom, 2'($urandom), 1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_vec++; if (op_count0 !== exp_count(m_cnt0) || op_count1 !== exp_count(m_cnt1)) begin n_err++;
            $display("FAIL opcount_wrap got %0d/%0d exp %0d/%0d", op_count0, op_count1, exp_count(m_cnt0), exp_count(m_cnt1)); end
    endtask

    initial begin
        test_reset();
        test_add32_r0();
        test_add16_r1();
        test_alternate();
        test_backpressure();
        test_idle_hold();
        test_random();
        test_reset_mid_exec();
        test_opcount();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
